// File: rtl/pwm_breathe.sv
// Breathing-LED PWM: a free-running phase counter compares against a per-frame
// duty latch, while a CE-stepped triangle ramp supplies the brightness level.
module pwm_breathe #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         CE,
    output logic         O,
    output logic [N-1:0] LEVEL,
    output logic         DIR,
    output logic         FRAME,
    output logic         COUT
);

    localparam logic [N-1:0] MAXV = '1;

    logic [N-1:0] phase_q, phase_d;
    logic [N-1:0] duty_q, duty_d;
    logic [N-1:0] level_q, level_d;
    logic         dir_q, dir_d;
    logic         frame_q, frame_d;
    logic         cout_q, cout_d;

    always_comb begin
        phase_d = phase_q + N'(1);
        // Duty only changes at the frame boundary, taking the pre-step level.
        duty_d  = (phase_q == MAXV) ? level_q : duty_q;
        frame_d = (phase_q == MAXV);
        level_d = level_q;
        dir_d   = dir_q;
        cout_d  = 1'b0;
        if (CE) begin
            if (!dir_q) begin
                if (level_q != MAXV) begin
                    level_d = level_q + N'(1);
                end else begin
                    level_d = MAXV - N'(1);
                    dir_d   = 1'b1;
                end
            end else begin
                if (level_q != '0) begin
                    level_d = level_q - N'(1);
                end else begin
                    level_d = N'(1);
                    dir_d   = 1'b0;
                    cout_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase_q <= '0;
            duty_q  <= '0;
            level_q <= '0;
            dir_q   <= 1'b0;
            frame_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            duty_q  <= duty_d;
            level_q <= level_d;
            dir_q   <= dir_d;
            frame_q <= frame_d;
            cout_q  <= cout_d;
        end
    end

    assign O     = (phase_q < duty_q);
    assign LEVEL = level_q;
    assign DIR   = dir_q;
    assign FRAME = frame_q;
    assign COUT  = cout_q;

endmodule

// File: tb/tb_pwm_breathe.sv
// Bench for pwm_breathe: step-counting reference model checked every cycle,
// a vector table for the ramp corners, and hand sequences for PWM/reset cases.
module tb_pwm_breathe;

    localparam int N    = 8;
    localparam int MAXV = (1 << N) - 1;
    localparam int FRM  = 1 << N;
    localparam int PER  = 2 * MAXV;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         CE = 1'b0;
    logic         O;
    logic [N-1:0] LEVEL;
    logic         DIR;
    logic         FRAME;
    logic         COUT;

    pwm_breathe #(.N(N)) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE), .O(O),
        .LEVEL(LEVEL), .DIR(DIR), .FRAME(FRAME), .COUT(COUT)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: k = CE steps since reset, t = cycles since reset.
    int k = 0;
    int t = 0;
    int duty_m = 0;
    int frame_m = 0;
    int cout_m = 0;

    // Position on the triangle in 1..PER once any step happened; 0 only after reset.
    function automatic int pos(input int kk);
        return (kk == 0) ? 0 : ((kk - 1) % PER) + 1;
    endfunction
    function automatic int m_level(input int kk);
        int p;
        p = pos(kk);
        return (p <= MAXV) ? p : PER - p;
    endfunction
    function automatic int m_dir(input int kk);
        return (pos(kk) > MAXV) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0d k=%0d)", name, act, exp, t, k);
        end
    endtask

    task automatic step(input logic ce, input logic rst);
        CE = ce;
        RESET = rst;
        @(posedge CLK);
        if (rst) begin
            k = 0; t = 0; duty_m = 0; frame_m = 0; cout_m = 0;
        end else begin
            frame_m = ((t % FRM) == MAXV) ? 1 : 0;
            if ((t % FRM) == MAXV) duty_m = m_level(k);
            cout_m = (ce && pos(k) == PER) ? 1 : 0;
            if (ce) k++;
            t++;
        end
        #1;
        check("level", int'(LEVEL), m_level(k));
        check("dir",   int'(DIR),   m_dir(k));
        check("cout",  int'(COUT),  cout_m);
        check("frame", int'(FRAME), frame_m);
        check("o",     int'(O),     ((t % FRM) < duty_m) ? 1 : 0);
    endtask

    task automatic idle_until_phase(input int ph);
        for (int i = 0; i < FRM && (t % FRM) != ph; i++) step(1'b0, 1'b0);
        check("phase_reached", t % FRM, ph);
    endtask

    task automatic count_frame(output int hi, output int first);
        hi = 0;
        first = int'(O);
        for (int i = 0; i < FRM; i++) begin
            if (O) hi++;
            step(1'b0, 1'b0);
        end
    endtask

    typedef struct {
        logic rst;
        logic ce;
        int   n;
        int   lvl;
        int   dir;
        int   cout;
    } vec_t;

    vec_t tbl[7];
    int hi, first;

    initial begin
        tbl[0] = '{rst: 1'b1, ce: 1'b1, n: 3,   lvl: 0,   dir: 0, cout: 0};
        tbl[1] = '{rst: 1'b0, ce: 1'b1, n: 255, lvl: 255, dir: 0, cout: 0};
        tbl[2] = '{rst: 1'b0, ce: 1'b1, n: 1,   lvl: 254, dir: 1, cout: 0};
        tbl[3] = '{rst: 1'b0, ce: 1'b1, n: 254, lvl: 0,   dir: 1, cout: 0};
        tbl[4] = '{rst: 1'b0, ce: 1'b1, n: 1,   lvl: 1,   dir: 0, cout: 1};
        tbl[5] = '{rst: 1'b0, ce: 1'b0, n: 1,   lvl: 1,   dir: 0, cout: 0};
        tbl[6] = '{rst: 1'b0, ce: 1'b1, n: 1,   lvl: 2,   dir: 0, cout: 0};

        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < tbl[r].n; i++) begin
                step(tbl[r].ce, tbl[r].rst);
                if (tbl[r].rst) begin
                    check("rst_o", int'(O), 0);
                    check("rst_frame", int'(FRAME), 0);
                end
            end
            check("tbl_level", int'(LEVEL), tbl[r].lvl);
            check("tbl_dir",   int'(DIR),   tbl[r].dir);
            check("tbl_cout",  int'(COUT),  tbl[r].cout);
        end

        // Duty 64 over one full frame, high from phase 0.
        step(1'b1, 1'b1);
        repeat (64) step(1'b1, 1'b0);
        idle_until_phase(0);
        count_frame(hi, first);
        check("duty64_count", hi, 64);
        check("duty64_first", first, 1);

        // Level 0 keeps O low for the whole frame.
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        idle_until_phase(0);
        count_frame(hi, first);
        check("duty0_count", hi, 0);

        // CE coincident with the frame load: old level this frame, stepped one next.
        step(1'b0, 1'b1);
        repeat (10) step(1'b1, 1'b0);
        idle_until_phase(MAXV);
        check("bnd_level_pre", int'(LEVEL), 10);
        step(1'b1, 1'b0);
        count_frame(hi, first);
        check("bnd_frame0", hi, 10);
        count_frame(hi, first);
        check("bnd_frame1", hi, 11);

        // Reset mid-ramp at level 100 falling, phase 37.
        step(1'b0, 1'b1);
        repeat (410) step(1'b1, 1'b0);
        idle_until_phase(37);
        check("mid_level", int'(LEVEL), 100);
        check("mid_dir", int'(DIR), 1);
        step(1'b1, 1'b1);
        check("mid_rst_level", int'(LEVEL), 0);
        check("mid_rst_dir", int'(DIR), 0);
        check("mid_rst_cout", int'(COUT), 0);
        check("mid_rst_frame", int'(FRAME), 0);
        check("mid_rst_o", int'(O), 0);
        step(1'b1, 1'b0);
        check("mid_restart_level", int'(LEVEL), 1);
        check("mid_restart_dir", int'(DIR), 0);

        // Random CE density with rare resets, checked against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 2) != 0), ($urandom_range(0, 699) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_breathe.md
PWM_BREATHE -- requirements
Module: pwm_breathe

Interface
REQ-001 SHALL have parameter N, default 8: width of PWM phase counter, brightness level and duty register.
REQ-002 SHALL have port CLK, input, 1 bit: sole clock; all state updates on rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: reset; one clock, synchronous, active-high.
REQ-004 SHALL have port CE, input, 1 bit: brightness-step tick, normally the COUT of the upstream prescaler counter; one-CLK pulses.
REQ-005 SHALL have port O, output, 1 bit: PWM LED drive.
REQ-006 SHALL have port LEVEL, output, N bits: current brightness level.
REQ-007 SHALL have port DIR, output, 1 bit: ramp direction; 0 = rising, 1 = falling.
REQ-008 SHALL have port FRAME, output, 1 bit: one-CLK pulse marking the first cycle of each PWM frame.
REQ-009 SHALL have port COUT, output, 1 bit: one-CLK pulse marking completion of a full breath cycle.

Function
REQ-010 SHALL hold an N-bit PHASE counter incrementing every CLK, with wrap from 2^N-1 to 0, independent of CE.
REQ-011 SHALL hold an N-bit DUTY register loaded from LEVEL only in the cycle where PHASE == 2^N-1, so the new duty applies from PHASE 0 (glitch-free; no mid-frame update).
REQ-012 SHALL drive O = (PHASE < DUTY), unsigned compare; DUTY 0 -> O constantly 0; DUTY 2^N-1 -> O high for 2^N-1 of 2^N cycles.
REQ-013 SHALL register FRAME high exactly in cycles where PHASE == 0, excluding the first cycle after reset release.
REQ-014 SHALL leave LEVEL and DIR unchanged in cycles with CE = 0.
REQ-015 SHALL, on CE = 1 with DIR = 0: if LEVEL < 2^N-1, set LEVEL <= LEVEL+1; if LEVEL == 2^N-1, set LEVEL <= 2^N-2 and DIR <= 1.
REQ-016 SHALL, on CE = 1 with DIR = 1: if LEVEL > 0, set LEVEL <= LEVEL-1; if LEVEL == 0, set LEVEL <= 1, DIR <= 0 and COUT <= 1 for the next cycle only.
REQ-017 SHALL give a breath period of 2*(2^N-1) CE ticks (510 for N=8), with LEVEL never leaving 0..2^N-1 (no arithmetic wrap).
REQ-018 SHALL, when CE = 1 coincides with the PHASE == 2^N-1 load, load DUTY with the pre-update LEVEL value; the stepped value applies at the next frame.
REQ-019 SHALL treat CE held high for consecutive cycles as one step per cycle.
REQ-020 SHALL register COUT and clear it in every cycle not following a REQ-016 turnaround.

Reset
REQ-021 SHALL, while RESET = 1 at a CLK edge, set PHASE = 0, DUTY = 0, LEVEL = 0, DIR = 0, COUT = 0, FRAME = 0; O is therefore 0.
REQ-022 SHALL give RESET priority over CE and frame load in the same cycle.
REQ-023 SHALL abort any ramp or frame in progress on reset mid-operation, with no residual COUT or FRAME pulse.
REQ-024 SHALL, on the first cycle after RESET falls, have PHASE = 1 on the following edge, and first raise FRAME when PHASE next wraps to 0.

Verification
REQ-025 SHALL cover reset: assert RESET 3 cycles with CE = 1 -> LEVEL = 0, DIR = 0, O = 0, COUT = 0, FRAME = 0 throughout.
REQ-026 SHALL cover rising-edge turnaround: 255 CE pulses from reset -> LEVEL = 255 with DIR = 0; 256th pulse -> LEVEL = 254 and DIR = 1.
REQ-027 SHALL cover full breath: 510 CE pulses from reset -> LEVEL back to 0 with DIR = 1; 511th pulse -> LEVEL = 1, DIR = 0, and COUT high exactly one CLK.
REQ-028 SHALL cover PWM duty: force LEVEL = 64, then run one full frame after load -> O high exactly 64 of 256 cycles, starting at PHASE 0; LEVEL = 0 -> O low all 256 cycles.
REQ-029 SHALL cover boundary load: CE pulse in the PHASE == 255 cycle with LEVEL = 10 rising -> DUTY = 10 for that frame (O high 10 cycles) and 11 in the next frame.
REQ-030 SHALL cover reset mid-ramp: RESET at LEVEL = 100, DIR = 1, PHASE = 37 -> next cycle all state 0, no COUT or FRAME pulse, and the ramp restarts from 0 upward.
